tqvp_dlmiles_i2c_byte_engine: RTL

Bit- and byte-level I2C controller engine that sits directly downstream of the I2C register/top block in the TinyQV peripheral.
- Consumes one command at a time (START, WRITE byte, READ byte, STOP) over a valid/ready handshake.
- Generates open-drain SCL/SDA timing from a programmable quarter-bit prescaler, with clock stretching.
- Returns one response per command: read data and ACK status.

---
 rtl/tqvp_dlmiles_i2c_byte_engine.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/tqvp_dlmiles_i2c_byte_engine.sv
// I2C bit/byte engine: runs one START/WRITE/READ/STOP command at a time as four
// quarter-bit phases per bit, driving open-drain SCL/SDA with clock stretching.
module tqvp_dlmiles_i2c_byte_engine #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] prescale,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_nack,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             rsp_nack,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             scl_oe,
  output logic             sda_oe
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BIT   = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] OP_START = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_READ  = 3'b011;
  localparam logic [2:0] OP_STOP  = 3'b100;

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       sh_q, sh_d;
  logic             nack_q, nack_d;
  logic             ack_q, ack_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_nack_q, rsp_nack_d;

  logic accept, stretch, last, rd;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_nack  = rsp_nack_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    op_d       = op_q;
    sh_d       = sh_q;
    nack_d     = nack_q;
    ack_d      = ack_q;
    scl_oe_d   = scl_oe_q;
    sda_oe_d   = sda_oe_q;
    rsp_data_d = rsp_data_q;
    rsp_nack_d = rsp_nack_q;

    accept  = cmd_valid && cmd_ready;
    rd      = (op_q == OP_READ);
    // Q1 freezes the timer while the bus still sees SCL low
    stretch = (phase_q == 2'd1) && !scl_in;
    last    = (cnt_q == '0) && !stretch;

    case (state_q)
      S_IDLE: ;
      S_DONE: state_d = S_IDLE;
      S_START, S_BIT, S_STOP: begin
        if (!last) begin
          if (!stretch) cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d   = prescale;
          phase_d = phase_q + 2'd1;
          if (state_q == S_BIT && phase_q == 2'd2) begin
            if (bit_q == 4'd8) ack_d = sda_in;
            else               sh_d  = {sh_q[6:0], sda_in};
          end
          case (state_q)
            S_START: begin
              if (phase_q == 2'd1) sda_oe_d = 1'b1;
              if (phase_q == 2'd2) scl_oe_d = 1'b1;
              if (phase_q == 2'd3) begin
                state_d    = S_DONE;
                rsp_nack_d = 1'b0;
              end
            end
            S_STOP: begin
              if (phase_q == 2'd0) scl_oe_d = 1'b0;
              if (phase_q == 2'd1) sda_oe_d = 1'b0;
              if (phase_q == 2'd3) begin
                state_d    = S_DONE;
                rsp_nack_d = 1'b0;
              end
            end
            default: begin
              if (phase_q == 2'd0) scl_oe_d = 1'b0;
              if (phase_q == 2'd2) scl_oe_d = 1'b1;
              if (phase_q == 2'd3) begin
                if (bit_q == 4'd8) begin
                  state_d    = S_DONE;
                  rsp_nack_d = rd ? nack_q : ack_q;
                  if (rd) rsp_data_d = sh_q;
                end else begin
                  // sh_q has already shifted, so bit [7] is the next data bit
                  bit_d    = bit_q + 4'd1;
                  scl_oe_d = 1'b1;
                  if (bit_q == 4'd7) sda_oe_d = rd ? ~nack_q : 1'b0;
                  else               sda_oe_d = rd ? 1'b0 : ~sh_q[7];
                end
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      op_d    = cmd_op;
      sh_d    = cmd_data;
      nack_d  = cmd_nack;
      phase_d = 2'd0;
      cnt_d   = prescale;
      bit_d   = 4'd0;
      case (cmd_op)
        OP_START: begin
          state_d  = S_START;
          scl_oe_d = 1'b0;
          sda_oe_d = 1'b0;
        end
        OP_WRITE: begin
          state_d  = S_BIT;
          scl_oe_d = 1'b1;
          sda_oe_d = ~cmd_data[7];
        end
        OP_READ: begin
          state_d  = S_BIT;
          scl_oe_d = 1'b1;
          sda_oe_d = 1'b0;
        end
        OP_STOP: begin
          state_d  = S_STOP;
          scl_oe_d = 1'b1;
          sda_oe_d = 1'b1;
        end
        default: begin
          state_d    = S_DONE;
          rsp_nack_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      op_q       <= '0;
      sh_q       <= '0;
      nack_q     <= 1'b0;
      ack_q      <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_nack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      op_q       <= op_d;
      sh_q       <= sh_d;
      nack_q     <= nack_d;
      ack_q      <= ack_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      rsp_data_q <= rsp_data_d;
      rsp_nack_q <= rsp_nack_d;
    end
  end

endmodule
